// File: rtl/entrada_serial_digitos_fd.sv
// rtl/entrada_serial_digitos_fd.sv - 7E2 serial receiver packing a "ddd#" message into 12-bit BCD (option macro: RX_PARITY_CHECK_EN)
module entrada_serial_digitos_fd #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        entrada_serial,
  output logic [11:0] dados,
  output logic        pronto,
  output logic        erro,
  output logic        recebendo
);

  localparam int            TW        = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] TICK_FULL = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TICK_HALF = TW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    F_IDLE,
    F_START,
    F_DATA,
    F_PARITY,
    F_STOP1,
    F_STOP2,
    F_ENTREGA
  } frame_state_t;

  typedef enum logic [1:0] {
    S_D0,
    S_D1,
    S_D2,
    S_HASH
  } seq_state_t;

  // line synchroniser and edge history (idle level is high)
  logic rx_meta;
  logic rx_sync;
  logic rx_prev;

  // frame FSM state
  frame_state_t  frame_state;
  frame_state_t  frame_next;
  logic [TW-1:0] tick;
  logic [TW-1:0] tick_next;
  logic [2:0]    bit_cnt;
  logic [2:0]    bit_cnt_next;
  logic [6:0]    shift;
  logic [6:0]    shift_next;
  logic          frame_err;
  logic          byte_strobe;
`ifdef RX_PARITY_CHECK_EN
  logic          par_ok;
  logic          par_ok_next;
`endif

  // sequence FSM state
  seq_state_t  seq_state;
  seq_state_t  seq_next;
  logic [11:0] staged;
  logic [11:0] staged_next;
  logic [11:0] dados_next;
  logic        pronto_next;
  logic        erro_next;
  logic        is_digit;
  logic        is_hash;

  // two-flop synchroniser on the async line plus one stage for falling-edge detection
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= entrada_serial;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // frame FSM registers: state, bit timing, bit count and shift register
  always_ff @(posedge clock) begin
    if (reset) begin
      frame_state <= F_IDLE;
      tick        <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
`ifdef RX_PARITY_CHECK_EN
      par_ok      <= 1'b0;
`endif
    end else begin
      frame_state <= frame_next;
      tick        <= tick_next;
      bit_cnt     <= bit_cnt_next;
      shift       <= shift_next;
`ifdef RX_PARITY_CHECK_EN
      par_ok      <= par_ok_next;
`endif
    end
  end

  // frame FSM next state: half-bit wait to centre on the start bit, then one sample per bit period
  always_comb begin
    frame_next   = frame_state;
    tick_next    = tick + 1'b1;
    bit_cnt_next = bit_cnt;
    shift_next   = shift;
    frame_err    = 1'b0;
    byte_strobe  = 1'b0;
`ifdef RX_PARITY_CHECK_EN
    par_ok_next  = par_ok;
`endif
    unique case (frame_state)
      F_IDLE: begin
        tick_next = '0;
        if (rx_prev && !rx_sync) begin
          frame_next = F_START;
        end
      end
      F_START: begin
        if (tick == TICK_HALF) begin
          tick_next    = '0;
          bit_cnt_next = '0;
          // a line already back high at mid start bit was only a glitch
          frame_next   = rx_sync ? F_IDLE : F_DATA;
        end
      end
      F_DATA: begin
        if (tick == TICK_FULL) begin
          tick_next    = '0;
          shift_next   = {rx_sync, shift[6:1]};
          bit_cnt_next = bit_cnt + 3'd1;
          if (bit_cnt == 3'd6) begin
            frame_next = F_PARITY;
          end
        end
      end
      F_PARITY: begin
        if (tick == TICK_FULL) begin
          tick_next   = '0;
`ifdef RX_PARITY_CHECK_EN
          par_ok_next = ~(^{shift, rx_sync});
`endif
          frame_next  = F_STOP1;
        end
      end
      F_STOP1: begin
        if (tick == TICK_FULL) begin
          tick_next = '0;
          if (!rx_sync) begin
            frame_err  = 1'b1;
            frame_next = F_IDLE;
          end else begin
            frame_next = F_STOP2;
          end
        end
      end
      F_STOP2: begin
        if (tick == TICK_FULL) begin
          tick_next = '0;
          if (!rx_sync) begin
            frame_err  = 1'b1;
            frame_next = F_IDLE;
          end else begin
            frame_next = F_ENTREGA;
          end
        end
      end
      F_ENTREGA: begin
        tick_next   = '0;
        byte_strobe = 1'b1;
        frame_next  = F_IDLE;
      end
      default: begin
        tick_next  = '0;
        frame_next = F_IDLE;
      end
    endcase
  end

  assign recebendo = (frame_state != F_IDLE) && (frame_state != F_ENTREGA);

  assign is_digit = (shift[6:4] == 3'b011) && (shift[3:0] <= 4'd9);
  assign is_hash  = (shift == 7'h23);

  // sequence FSM registers and the registered output pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      seq_state <= S_D0;
      staged    <= '0;
      dados     <= '0;
      pronto    <= 1'b0;
      erro      <= 1'b0;
    end else begin
      seq_state <= seq_next;
      staged    <= staged_next;
      dados     <= dados_next;
      pronto    <= pronto_next;
      erro      <= erro_next;
    end
  end

  // sequence FSM next state: three ASCII digits then '#', anything else restarts the message
  always_comb begin
    seq_next    = seq_state;
    staged_next = staged;
    dados_next  = dados;
    pronto_next = 1'b0;
    erro_next   = frame_err;
    if (frame_err) begin
      seq_next = S_D0;
    end else if (byte_strobe) begin
`ifdef RX_PARITY_CHECK_EN
      if (!par_ok) begin
        erro_next = 1'b1;
        seq_next  = S_D0;
      end else
`endif
      begin
        unique case (seq_state)
          S_D0: begin
            if (is_digit) begin
              staged_next[11:8] = shift[3:0];
              seq_next          = S_D1;
            end else begin
              erro_next = 1'b1;
              seq_next  = S_D0;
            end
          end
          S_D1: begin
            if (is_digit) begin
              staged_next[7:4] = shift[3:0];
              seq_next         = S_D2;
            end else begin
              erro_next = 1'b1;
              seq_next  = S_D0;
            end
          end
          S_D2: begin
            if (is_digit) begin
              staged_next[3:0] = shift[3:0];
              seq_next         = S_HASH;
            end else begin
              erro_next = 1'b1;
              seq_next  = S_D0;
            end
          end
          S_HASH: begin
            if (is_hash) begin
              dados_next  = staged;
              pronto_next = 1'b1;
            end else begin
              erro_next = 1'b1;
            end
            seq_next = S_D0;
          end
          default: begin
            seq_next = S_D0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_entrada_serial_digitos_fd.sv
// tb/tb_entrada_serial_digitos_fd.sv - table-driven scoreboard bench for entrada_serial_digitos_fd
module tb_entrada_serial_digitos_fd;

  localparam int CPB = 4;

  typedef struct {
    string       name;
    logic [31:0] bytes;
    int          n;
    int          gap;
    logic [11:0] exp_dados;
    int          exp_pronto;
    int          exp_erro;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        entrada_serial;
  logic [11:0] dados;
  logic        pronto;
  logic        erro;
  logic        recebendo;

  int checks     = 0;
  int failures   = 0;
  int pronto_cnt = 0;
  int erro_cnt   = 0;
  logic [11:0] exp_q[$];

  always #5 clock = ~clock;

  entrada_serial_digitos_fd #(.CLKS_PER_BIT(CPB)) dut (
    .clock          (clock),
    .reset          (reset),
    .entrada_serial (entrada_serial),
    .dados          (dados),
    .pronto         (pronto),
    .erro           (erro),
    .recebendo      (recebendo)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [31:0] b, input int n, input int gap,
                              input logic [11:0] d, input int p, input int e);
    vec_t v;
    v.name = name; v.bytes = b; v.n = n; v.gap = gap;
    v.exp_dados = d; v.exp_pronto = p; v.exp_erro = e;
    return v;
  endfunction

  // one 7E2 frame, starting and ending on a falling clock edge
  task automatic send_frame(input logic [7:0] ch, input bit bad_par, input bit bad_stop2);
    logic par;
    par = ^ch[6:0];
    if (bad_par) par = ~par;
    entrada_serial = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 7; i++) begin
      entrada_serial = ch[i];
      repeat (CPB) @(negedge clock);
    end
    entrada_serial = par;
    check("recebendo_mid_frame", recebendo, 1);
    repeat (CPB) @(negedge clock);
    entrada_serial = 1'b1;
    repeat (CPB) @(negedge clock);
    entrada_serial = bad_stop2 ? 1'b0 : 1'b1;
    repeat (CPB) @(negedge clock);
    entrada_serial = 1'b1;
  endtask

  task automatic send_bytes(input logic [31:0] b, input int n);
    for (int i = 0; i < n; i++) send_frame(b[31-8*i -: 8], 1'b0, 1'b0);
  endtask

  task automatic run_vec(input vec_t t);
    int p0;
    int e0;
    p0 = pronto_cnt;
    e0 = erro_cnt;
    if (t.exp_pronto != 0) exp_q.push_back(t.exp_dados);
    for (int i = 0; i < t.n; i++) begin
      send_frame(t.bytes[31-8*i -: 8], 1'b0, 1'b0);
      repeat (t.gap) @(negedge clock);
    end
    repeat (12) @(negedge clock);
    check({t.name, " pronto_count"}, pronto_cnt - p0, t.exp_pronto);
    check({t.name, " erro_count"}, erro_cnt - e0, t.exp_erro);
    check({t.name, " dados"}, dados, t.exp_dados);
  endtask

  // output monitor: pulse rules, scoreboard pop on pronto, dados stability
  initial begin
    logic [11:0] e;
    logic [11:0] prev_dados;
    logic        prev_pronto;
    logic        prev_erro;
    prev_dados  = '0;
    prev_pronto = 1'b0;
    prev_erro   = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_pronto = 1'b0;
        prev_erro   = 1'b0;
        prev_dados  = dados;
      end else begin
        if (pronto || erro) check("pronto_erro_exclusive", pronto & erro, 0);
        if (pronto) begin
          check("pronto_width", prev_pronto, 0);
          pronto_cnt++;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pronto: dados=%h with no message expected", dados);
          end else begin
            e = exp_q.pop_front();
            check("dados_on_pronto", dados, e);
          end
        end
        if (erro) begin
          check("erro_width", prev_erro, 0);
          erro_cnt++;
        end
        if (dados !== prev_dados) check("dados_change_needs_pronto", pronto, 1);
        prev_pronto = pronto;
        prev_erro   = erro;
        prev_dados  = dados;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[10];
    int   p0;
    int   e0;
    bit   seen;

    vecs[0] = mk("msg_123",      "123#",           4, 3, 12'h123, 1, 0);
    vecs[1] = mk("msg_905_b2b",  "905#",           4, 0, 12'h905, 1, 0);
    vecs[2] = mk("short_12#",    {"12#", 8'h00},   3, 0, 12'h905, 0, 1);
    vecs[3] = mk("msg_456",      "456#",           4, 2, 12'h456, 1, 0);
    vecs[4] = mk("no_hash_1234", "1234",           4, 0, 12'h456, 0, 1);
    vecs[5] = mk("below_0",      {"/", 24'h0},     1, 0, 12'h456, 0, 1);
    vecs[6] = mk("above_9",      {":", 24'h0},     1, 0, 12'h456, 0, 1);
    vecs[7] = mk("hash_first",   {"#", 24'h0},     1, 0, 12'h456, 0, 1);
    vecs[8] = mk("msg_000",      "000#",           4, 1, 12'h000, 1, 0);
    vecs[9] = mk("msg_999_b2b",  "999#",           4, 0, 12'h999, 1, 0);

    reset = 1'b1;
    entrada_serial = 1'b1;
    repeat (3) @(negedge clock);
    check("reset dados", dados, 0);
    check("reset pronto", pronto, 0);
    check("reset erro", erro, 0);
    check("reset recebendo", recebendo, 0);
    reset = 1'b0;
    repeat (4) @(negedge clock);

    for (int v = 0; v < 10; v++) run_vec(vecs[v]);

    // digit with a wrong parity bit
    p0 = pronto_cnt;
    e0 = erro_cnt;
`ifdef RX_PARITY_CHECK_EN
    send_frame("7", 1'b1, 1'b0);
    repeat (12) @(negedge clock);
    check("bad_parity erro_count", erro_cnt - e0, 1);
    check("bad_parity pronto_count", pronto_cnt - p0, 0);
    exp_q.push_back(12'h123);
    send_bytes("123#", 4);
    repeat (12) @(negedge clock);
    check("after_parity dados", dados, 12'h123);
`else
    exp_q.push_back(12'h712);
    send_frame("7", 1'b1, 1'b0);
    send_bytes({"12#", 8'h00}, 3);
    repeat (12) @(negedge clock);
    check("parity_ignored erro_count", erro_cnt - e0, 0);
    check("parity_ignored dados", dados, 12'h712);
`endif
    check("after_parity pronto_count", pronto_cnt - p0, 1);

    // framing error on the second stop bit
    p0 = pronto_cnt;
    e0 = erro_cnt;
    send_frame("8", 1'b0, 1'b1);
    repeat (12) @(negedge clock);
    check("bad_stop2 erro_count", erro_cnt - e0, 1);
    check("bad_stop2 pronto_count", pronto_cnt - p0, 0);

    // one-cycle low glitch on the idle line
    e0 = erro_cnt;
    entrada_serial = 1'b0;
    @(negedge clock);
    entrada_serial = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge clock);
      if (recebendo) seen = 1'b1;
    end
    check("glitch recebendo_rises", seen, 1);
    seen = 1'b0;
    for (int i = 0; i < CPB / 2 + 2 && !seen; i++) begin
      @(negedge clock);
      if (!recebendo) seen = 1'b1;
    end
    check("glitch recebendo_falls", seen, 1);
    repeat (8) @(negedge clock);
    check("glitch erro_count", erro_cnt - e0, 0);

    // reset in the middle of the second digit's data bits
    p0 = pronto_cnt;
    e0 = erro_cnt;
    send_frame("1", 1'b0, 1'b0);
    entrada_serial = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      entrada_serial = (i == 1);
      repeat (CPB) @(negedge clock);
    end
    reset = 1'b1;
    entrada_serial = 1'b1;
    repeat (2) @(negedge clock);
    check("midreset dados", dados, 0);
    check("midreset pronto", pronto, 0);
    check("midreset erro", erro, 0);
    check("midreset recebendo", recebendo, 0);
    reset = 1'b0;
    repeat (8) @(negedge clock);
    check("midreset no_pulses", (pronto_cnt - p0) + (erro_cnt - e0), 0);

    // new message after reset, with exact pronto latency
    p0 = pronto_cnt;
    e0 = erro_cnt;
    exp_q.push_back(12'h321);
    send_bytes({"321", 8'h00}, 3);
    send_frame("#", 1'b0, 1'b0);
    @(negedge clock);
    check("latency pronto_not_early", pronto, 0);
    @(negedge clock);
    check("latency pronto_on_time", pronto, 1);
    check("latency dados", dados, 12'h321);
    repeat (10) @(negedge clock);
    check("post_reset pronto_count", pronto_cnt - p0, 1);
    check("post_reset erro_count", erro_cnt - e0, 0);
    check("scoreboard drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
